// File: rtl/ufpgapll_pkg.sv
// ufpgapll_pkg
//   Constants shared by the feedback conditioner, the PLL core and the display
//   logic. The raw frequency/time limits are kept next to the clock counts
//   derived from them, so that all three blocks use the same thresholds.
//   Contents:
//     XTAL_FREQ, FREQ_LOCKOUT_LO/HI, LOCKOUT_TIME_US   raw limits
//     CYC_LO, CYC_HI, LOCKOUT_CYCLES                  limits converted to xtal clocks
//     fb_edge_t                                       rise/fall strobe pair
//     ctr_w()                                         counter width for a maximum value
package ufpgapll_pkg;

  localparam int unsigned XTAL_FREQ        = 50_000_000;  // Hz
  localparam int unsigned FREQ_LOCKOUT_LO  = 50_000;      // Hz, slower input is locked out
  localparam int unsigned FREQ_LOCKOUT_HI  = 210_000;     // Hz, faster input is locked out
  localparam int unsigned LOCKOUT_TIME_US  = 1_000;       // lockout hold time

  // Half-period limits: a half period lasts XTAL_FREQ / (2*f) clocks.
  localparam int unsigned CYC_LO         = XTAL_FREQ / (2 * FREQ_LOCKOUT_LO);   // 500
  localparam int unsigned CYC_HI         = XTAL_FREQ / (2 * FREQ_LOCKOUT_HI);   // 119
  localparam int unsigned LOCKOUT_CYCLES = (XTAL_FREQ / 1_000_000) * LOCKOUT_TIME_US; // 50000

  localparam int unsigned GLITCH_CYCLES_DEF = 4;
  localparam int unsigned PERIOD_W_DEF      = 16;

  typedef struct packed {
    logic rise;
    logic fall;
  } fb_edge_t;

  // Bits needed to hold the values 0..max_val.
  function automatic int unsigned ctr_w(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fb_conditioner_if.sv
// fb_conditioner_if
//   Signal bundle between the feedback conditioner and its user (PLL core or
//   testbench).
//   master: drives fb_u / clr_flags, reads the conditioned results
//   slave : the conditioner itself
//   Signals:
//     fb_u          raw feedback pin
//     clr_flags     clears the sticky lock_*_seen flags
//     fb            synchronised, deglitched level
//     fb_rise/fall  1-clk edge strobes of fb
//     period        last rising-to-rising period in clocks
//     period_valid  1-clk pulse when period updates
//     lockout       frequency lockout active
//     lock_lo_seen  sticky: too-slow trigger seen
//     lock_hi_seen  sticky: too-fast trigger seen
interface fb_conditioner_if
  import ufpgapll_pkg::*;
#(
  parameter int unsigned PERIOD_W = PERIOD_W_DEF
);

  logic                fb_u;
  logic                clr_flags;
  logic                fb;
  logic                fb_rise;
  logic                fb_fall;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;
  logic                lockout;
  logic                lock_lo_seen;
  logic                lock_hi_seen;

  modport master (
    output fb_u, clr_flags,
    input  fb, fb_rise, fb_fall, period, period_valid,
           lockout, lock_lo_seen, lock_hi_seen
  );

  modport slave (
    input  fb_u, clr_flags,
    output fb, fb_rise, fb_fall, period, period_valid,
           lockout, lock_lo_seen, lock_hi_seen
  );

endinterface

// File: rtl/fb_deglitch.sv
// fb_deglitch
//   Two-flop synchroniser for the raw feedback pin followed by a glitch filter:
//   fb only follows the synchronised pin once it has disagreed with fb for
//   GLITCH_CYCLES consecutive clocks. Pin edge to fb change is 2+GLITCH_CYCLES
//   clocks. Also produces 1-clk rise/fall strobes in the first cycle fb shows
//   its new level.
//   Ports:
//     clk    in   clock
//     rst_n  in   asynchronous reset, active low
//     fb_u   in   raw, unsynchronised pin
//     fb     out  deglitched level (registered)
//     edges  out  rise/fall strobes (decoded from fb and its delayed copy)
module fb_deglitch
  import ufpgapll_pkg::*;
#(
  parameter int unsigned GLITCH_CYCLES = GLITCH_CYCLES_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     fb_u,
  output logic     fb,
  output fb_edge_t edges
);

  localparam int unsigned GW = ctr_w(GLITCH_CYCLES);

  logic          s0_reg;
  logic          s1_reg;
  logic          fb_reg;
  logic          fb_d_reg;
  logic [GW-1:0] gcnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_reg   <= 1'b0;
      s1_reg   <= 1'b0;
      fb_reg   <= 1'b0;
      fb_d_reg <= 1'b0;
      gcnt_reg <= '0;
    end else begin
      s0_reg   <= fb_u;
      s1_reg   <= s0_reg;
      fb_d_reg <= fb_reg;
      // Any sample that agrees with fb restarts the count, so only an
      // uninterrupted run of GLITCH_CYCLES disagreeing samples flips fb.
      if (s1_reg != fb_reg) begin
        if (gcnt_reg == GW'(GLITCH_CYCLES - 1)) begin
          fb_reg   <= s1_reg;
          gcnt_reg <= '0;
        end else begin
          gcnt_reg <= gcnt_reg + 1'b1;
        end
      end else begin
        gcnt_reg <= '0;
      end
    end
  end

  assign fb         = fb_reg;
  assign edges.rise = fb_reg & ~fb_d_reg;
  assign edges.fall = ~fb_reg & fb_d_reg;

endmodule

// File: rtl/fb_conditioner.sv
// fb_conditioner
//   Input stage in front of the software PLL core. Cleans up the feedback pin
//   (via fb_deglitch), measures the rising-to-rising period in xtal clocks and
//   raises a frequency lockout when a half period is too long (input stopped or
//   too slow) or too short (input too fast).
//   Ports:
//     clk    in     xtal clock (50 MHz)
//     rst_n  in     asynchronous reset, active low
//     bus    slave  fb_conditioner_if: fb_u/clr_flags in; fb, fb_rise, fb_fall,
//                   period, period_valid, lockout, lock_lo_seen, lock_hi_seen out
module fb_conditioner
  import ufpgapll_pkg::*;
#(
  parameter int unsigned GLITCH_CYCLES  = GLITCH_CYCLES_DEF,
  parameter int unsigned CYC_LO_P       = CYC_LO,
  parameter int unsigned CYC_HI_P       = CYC_HI,
  parameter int unsigned LOCKOUT_CYC_P  = LOCKOUT_CYCLES,
  parameter int unsigned PERIOD_W       = PERIOD_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  fb_conditioner_if.slave bus
);

  localparam int unsigned HW = ctr_w(CYC_LO_P);
  localparam int unsigned TW = ctr_w(LOCKOUT_CYC_P);

  logic     fb;
  fb_edge_t edges;
  logic     edge_any;

  fb_deglitch #(
    .GLITCH_CYCLES (GLITCH_CYCLES)
  ) u_deglitch (
    .clk   (clk),
    .rst_n (rst_n),
    .fb_u  (bus.fb_u),
    .fb    (fb),
    .edges (edges)
  );

  assign edge_any = edges.rise | edges.fall;

  // ---------------------------------------------------------------- half period
  logic [HW-1:0] half_ctr_reg;
  logic          trig_lo;
  logic          trig_hi;

  // half_ctr passes CYC_LO-1 exactly once before saturating at CYC_LO, so a
  // dropout triggers once rather than on every clock.
  assign trig_lo = ~edge_any & (half_ctr_reg == HW'(CYC_LO_P - 1));
  assign trig_hi = edge_any & (half_ctr_reg <= HW'(CYC_HI_P));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Start above CYC_HI so the very first edge after reset is not "too fast".
      half_ctr_reg <= HW'(CYC_HI_P + 1);
    end else if (edge_any) begin
      half_ctr_reg <= '0;
    end else if (half_ctr_reg < HW'(CYC_LO_P)) begin
      half_ctr_reg <= half_ctr_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------- lockout
  logic [TW-1:0] timer_reg;
  logic [TW-1:0] timer_next;
  logic          lockout_reg;
  logic          lock_lo_seen_reg;
  logic          lock_hi_seen_reg;

  always_comb begin
    timer_next = timer_reg;
    if (trig_lo | trig_hi) begin
      timer_next = TW'(LOCKOUT_CYC_P);
    end else if (timer_reg != '0) begin
      timer_next = timer_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_reg        <= '0;
      lockout_reg      <= 1'b0;
      lock_lo_seen_reg <= 1'b0;
      lock_hi_seen_reg <= 1'b0;
    end else begin
      timer_reg   <= timer_next;
      // Registered copy of (timer != 0), taken from the next-state value so it
      // tracks timer_reg exactly.
      lockout_reg <= (timer_next != '0);
      // A trigger in the same cycle as clr_flags keeps the flag set.
      if (trig_lo) begin
        lock_lo_seen_reg <= 1'b1;
      end else if (bus.clr_flags) begin
        lock_lo_seen_reg <= 1'b0;
      end
      if (trig_hi) begin
        lock_hi_seen_reg <= 1'b1;
      end else if (bus.clr_flags) begin
        lock_hi_seen_reg <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- period
  logic [PERIOD_W-1:0] period_ctr_reg;
  logic [PERIOD_W-1:0] period_reg;
  logic                period_valid_reg;
  logic                armed_reg;
  logic                period_sat;

  assign period_sat = (period_ctr_reg == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_ctr_reg   <= '0;
      period_reg       <= '0;
      period_valid_reg <= 1'b0;
      armed_reg        <= 1'b0;
    end else begin
      period_valid_reg <= 1'b0;
      if (edges.rise) begin
        // The rise cycle itself is the first clock of the new period.
        period_ctr_reg <= PERIOD_W'(1);
        armed_reg      <= 1'b1;
        // An unarmed rise (first after reset or after an overflow) only
        // starts the measurement; a saturated count is not a real period.
        if (armed_reg && !period_sat) begin
          period_reg       <= period_ctr_reg;
          period_valid_reg <= 1'b1;
        end
      end else begin
        if (!period_sat) begin
          period_ctr_reg <= period_ctr_reg + 1'b1;
        end else begin
          armed_reg <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bus.fb           = fb;
  assign bus.fb_rise      = edges.rise;
  assign bus.fb_fall      = edges.fall;
  assign bus.period       = period_reg;
  assign bus.period_valid = period_valid_reg;
  assign bus.lockout      = lockout_reg;
  assign bus.lock_lo_seen = lock_lo_seen_reg;
  assign bus.lock_hi_seen = lock_hi_seen_reg;

endmodule

// File: tb/tb_fb_conditioner.sv
// tb_fb_conditioner
//   Directed bench for fb_conditioner: glitch filter, 125 kHz period
//   measurement, dropout lockout, 250 kHz lockout with a clr_flags collision,
//   and reset in the middle of a lockout.
module tb_fb_conditioner;
  import ufpgapll_pkg::*;

  logic clk;
  logic rst_n;

  fb_conditioner_if #(.PERIOD_W(16)) bus ();

  fb_conditioner dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Hard time limit: the whole run is about 55k clocks.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %-16s got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %-16s got=%0d", tag, got);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  int   cyc = 0;
  int   rise_cnt = 0, fall_cnt = 0, pv_cnt = 0, pv_rise_idx = 0, bad_period = 0;
  int   last_edge_cyc = 0, lock_rise_cyc = 0, lock_fall_cyc = 0;
  int   lock_high_cycles = 0, lock_low_cycles = 0;
  int   exp_period = 0;
  logic lock_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.fb_rise) rise_cnt <= rise_cnt + 1;
    if (bus.fb_fall) fall_cnt <= fall_cnt + 1;
    if (bus.fb_rise | bus.fb_fall) last_edge_cyc <= cyc;
    if (bus.period_valid) begin
      pv_cnt      <= pv_cnt + 1;
      pv_rise_idx <= rise_cnt;
      if (32'(bus.period) != exp_period) bad_period <= bad_period + 1;
    end
    if (bus.lockout && !lock_prev) lock_rise_cyc <= cyc;
    if (!bus.lockout && lock_prev) lock_fall_cyc <= cyc;
    lock_prev <= bus.lockout;
    if (bus.lockout) lock_high_cycles <= lock_high_cycles + 1;
    else             lock_low_cycles  <= lock_low_cycles + 1;
  end

  // Inputs change and checks happen 1 time unit after a falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic square(input int half, input int n);
    for (int i = 0; i < n; i++) begin
      bus.fb_u = ~bus.fb_u;
      step(half);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, 32'({bus.fb, bus.fb_rise, bus.fb_fall, bus.period_valid,
                                bus.lockout, bus.lock_lo_seen, bus.lock_hi_seen}), 32'd0);
    check({tag, "_period"}, 32'(bus.period), 32'd0);
  endtask

  int b_rise, b_fall, b_pv, b_bad, b_hi, b_lo;

  initial begin
    rst_n         = 1'b0;
    bus.fb_u      = 1'b0;
    bus.clr_flags = 1'b0;
    step(3);
    check_all_zero("rst");
    rst_n = 1'b1;
    step(2);
    check("rst_no_lockout", 32'(bus.lockout), 32'd0);

    // ---- glitch filter: 3-clk pulse ignored, 4-clk pulse passes
    b_rise = rise_cnt; b_fall = fall_cnt; b_pv = pv_cnt;
    bus.fb_u = 1'b1; step(3); bus.fb_u = 1'b0; step(12);
    check("g3_fb",   32'(bus.fb), 32'd0);
    check("g3_rises", 32'(rise_cnt - b_rise), 32'd0);
    check("g3_pv",   32'(pv_cnt - b_pv), 32'd0);
    bus.fb_u = 1'b1; step(4); bus.fb_u = 1'b0; step(2);
    check("g4_fb",   32'(bus.fb), 32'd1);
    check("g4_rise", 32'(bus.fb_rise), 32'd1);
    step(10);
    check("g4_fb_back", 32'(bus.fb), 32'd0);
    check("g4_falls", 32'(fall_cnt - b_fall), 32'd1);

    // ---- 125 kHz square: 200-clk half periods
    rst_n = 1'b0; step(2); rst_n = 1'b1;
    b_rise = rise_cnt; b_pv = pv_cnt; b_bad = bad_period; b_hi = lock_high_cycles;
    exp_period = 400;
    bus.fb_u = 1'b1;
    step(5);
    check("lat_fb_5clk", 32'(bus.fb), 32'd0);
    step(1);
    check("lat_fb_6clk", 32'(bus.fb), 32'd1);
    step(194);
    square(200, 8);  // fb_u rises at 0, 400, 800, 1200, 1600
    check("t1_rises",   32'(rise_cnt - b_rise), 32'd5);
    check("t1_pv",      32'(pv_cnt - b_pv), 32'd4);
    check("t1_bad_per", 32'(bad_period - b_bad), 32'd0);
    check("t1_period",  32'(bus.period), 32'd400);
    check("t1_lockout", 32'(lock_high_cycles - b_hi), 32'd0);

    // ---- input stops (held high): dropout lockout
    for (int i = 0; i < 700 && !bus.lockout; i++) step(1);
    check("t3_lockout", 32'(bus.lockout), 32'd1);
    // edge strobe cycle, then CYC_LO clocks of counting before the register sets
    check("t3_delay",   32'(lock_rise_cyc - last_edge_cyc), 32'(CYC_LO + 1));
    check("t3_lo_seen", 32'(bus.lock_lo_seen), 32'd1);
    check("t3_hi_seen", 32'(bus.lock_hi_seen), 32'd0);
    for (int i = 0; i < LOCKOUT_CYCLES + 100 && bus.lockout; i++) step(1);
    check("t3_release", 32'(bus.lockout), 32'd0);
    check("t3_hold",    32'(lock_fall_cyc - lock_rise_cyc), 32'(LOCKOUT_CYCLES));
    check("t3_sticky",  32'(bus.lock_lo_seen), 32'd1);
    bus.clr_flags = 1'b1; step(1); bus.clr_flags = 1'b0; step(1);
    check("clr_lo_seen", 32'(bus.lock_lo_seen), 32'd0);

    // ---- 250 kHz: second fb edge is too fast; clr_flags collides with trigger
    bus.fb_u = 1'b0; step(100);
    bus.fb_u = 1'b1; step(6);
    check("t4_rise",       32'(bus.fb_rise), 32'd1);
    check("t4_pre_lock",   32'(bus.lockout), 32'd0);
    bus.clr_flags = 1'b1; step(1); bus.clr_flags = 1'b0;
    check("t4_lockout",    32'(bus.lockout), 32'd1);
    check("t6_set_wins",   32'(bus.lock_hi_seen), 32'd1);
    step(1);
    check("t6_sticky",     32'(bus.lock_hi_seen), 32'd1);
    b_pv = pv_cnt; b_bad = bad_period; b_lo = lock_low_cycles;
    exp_period = 200;
    step(92);
    square(100, 6);  // fb_u rises every 200 clocks
    check("t4_pv",         32'(pv_cnt - b_pv), 32'd3);
    check("t4_bad_per",    32'(bad_period - b_bad), 32'd0);
    check("t4_period",     32'(bus.period), 32'd200);
    check("t4_held",       32'(lock_low_cycles - b_lo), 32'd0);
    check("t4_lo_seen",    32'(bus.lock_lo_seen), 32'd0);

    // ---- reset mid-lockout with a period pending
    rst_n = 1'b0; bus.fb_u = 1'b0;
    #1;
    check_all_zero("t5_async");
    step(3);
    rst_n = 1'b1;
    step(10);
    check("t5_lockout", 32'(bus.lockout), 32'd0);
    b_rise = rise_cnt; b_pv = pv_cnt; b_bad = bad_period;
    exp_period = 400;
    bus.fb_u = 1'b1; step(200);
    check("t5_first_rise", 32'(pv_cnt - b_pv), 32'd0);
    bus.fb_u = 1'b0; step(200);
    bus.fb_u = 1'b1; step(20);
    check("t5_pv",        32'(pv_cnt - b_pv), 32'd1);
    check("t5_pv_on_2nd", 32'(pv_rise_idx - b_rise), 32'd2);
    check("t5_period",    32'(bus.period), 32'd400);
    check("t5_bad_per",   32'(bad_period - b_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
